// File: rtl/mac_dot8_pkg.sv
// Shared types and helpers for the 8-lane dot-product MAC sequencer.
// Saturating accumulation is enabled by defining MAC_DOT8_SAT_EN.
package mac_dot8_pkg;

  localparam int LANES      = 8;
  localparam int LANE_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp result: value plus a flag telling whether it was clamped.
  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } sat_t;

  // Pull lane 'sel' (each 'w' bits wide, w < 32) out of a packed vector.
  function automatic logic [31:0] lane_get(input logic [255:0] vec,
                                           input int unsigned w,
                                           input logic [LANE_IDX_W-1:0] sel);
    logic [255:0] t;
    t = vec >> (w * 32'(sel));
    return t[31:0];
  endfunction

  // Clamp an exact (wide, signed) sum into a w-bit result (w < 64).
  // tc=1: signed range; tc=0: unsigned range [0, 2^w-1].
  function automatic sat_t sat_clamp(input logic signed [65:0] wide,
                                     input int unsigned w,
                                     input logic tc);
    logic signed [65:0] hi;
    logic signed [65:0] lo;
    sat_t r;
    if (tc) begin
      hi = (66'sd1 <<< (w - 1)) - 66'sd1;
      lo = -(66'sd1 <<< (w - 1));
    end else begin
      hi = (66'sd1 <<< w) - 66'sd1;
      lo = '0;
    end
    r.ovf = 1'b0;
    r.val = wide[63:0];
    if (wide > hi) begin
      r.ovf = 1'b1;
      r.val = hi[63:0];
    end else if (wide < lo) begin
      r.ovf = 1'b1;
      r.val = lo[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dot8_lane_mac.sv
// Combinational lane MAC: selects one A lane, multiplies by the B lane
// and adds the running accumulator. Two's-complement or unsigned per tc.
// With MAC_DOT8_SAT_EN the add clamps and flags ovf; otherwise it wraps.
module dot8_lane_mac
  import mac_dot8_pkg::*;
#(
  parameter int A_width   = 8,
  parameter int B_width   = 8,
  parameter int SUM_width = 22
) (
  input  logic [LANE_IDX_W-1:0]    sel,
  input  logic [A_width*LANES-1:0] a_vec,
  input  logic [B_width-1:0]       b_lane,
  input  logic [SUM_width-1:0]     c,
  input  logic                     tc,
  output logic [SUM_width-1:0]     sum,
  output logic                     ovf
);

  // One extra bit per operand lets a single signed multiplier cover both modes.
  localparam int P_W = A_width + B_width + 2;

  logic [31:0]               a_word;
  logic [A_width-1:0]        a_lane;
  logic [31-A_width:0]       unused_a_hi;
  logic signed [A_width:0]   a_x;
  logic signed [B_width:0]   b_x;
  logic signed [P_W-1:0]     prod;
  logic signed [SUM_width-1:0] prod_ext;

  assign a_word      = lane_get(256'(a_vec), A_width, sel);
  assign a_lane      = a_word[A_width-1:0];
  assign unused_a_hi = a_word[31:A_width];

  // Extend operands (sign or zero), form the exact product, widen to SUM_width.
  always_comb begin
    a_x      = $signed({tc & a_lane[A_width-1], a_lane});
    b_x      = $signed({tc & b_lane[B_width-1], b_lane});
    prod     = P_W'(a_x) * P_W'(b_x);
    prod_ext = SUM_width'(prod);
  end

`ifdef MAC_DOT8_SAT_EN
  logic signed [SUM_width+1:0] wide;
  logic signed [65:0]          wide66;
  sat_t                        sat_r;
  logic [63-SUM_width:0]       unused_sat_hi;

  // Exact sum in two guard bits, then clamp to the SUM_width range.
  always_comb begin
    wide   = $signed({{2{tc & c[SUM_width-1]}}, c}) + (SUM_width+2)'(prod_ext);
    wide66 = 66'(wide);
    sat_r  = sat_clamp(wide66, SUM_width, tc);
    sum    = sat_r.val[SUM_width-1:0];
    ovf    = sat_r.ovf;
  end
  assign unused_sat_hi = sat_r.val[63:SUM_width];
`else
  // Modulo 2^SUM_width accumulate; never flags overflow.
  always_comb begin
    sum = c + $unsigned(prod_ext);
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/mac_dot8_sequencer.sv
// 8-lane dot-product sequencer: accepts an A/B/seed bundle, walks lanes
// 0..7 through dot8_lane_mac one per cycle, presents the sum on out_*.
// Define MAC_DOT8_SAT_EN for saturating accumulation with sticky out_ovf.
module mac_dot8_sequencer
  import mac_dot8_pkg::*;
#(
  parameter int A_width   = 8,
  parameter int B_width   = 8,
  parameter int SUM_width = 22
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_width*LANES-1:0] in_a,
  input  logic [B_width*LANES-1:0] in_b,
  input  logic [SUM_width-1:0]     in_c,
  input  logic                     in_tc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_width-1:0]     out_sum,
  output logic                     out_ovf,
  output logic                     busy
);

  state_t                   state, state_n;
  logic [LANE_IDX_W-1:0]    lane;
  logic [A_width*LANES-1:0] a_reg;
  logic [B_width*LANES-1:0] b_reg;
  logic                     tc_reg;
  logic [SUM_width-1:0]     acc;
  logic                     ovf_reg;

  logic [31:0]              b_word;
  logic [B_width-1:0]       b_lane;
  logic [31-B_width:0]      unused_b_hi;
  logic [SUM_width-1:0]     mac_sum;
  logic                     mac_ovf;

  assign b_word      = lane_get(256'(b_reg), B_width, lane);
  assign b_lane      = b_word[B_width-1:0];
  assign unused_b_hi = b_word[31:B_width];

  dot8_lane_mac #(
    .A_width  (A_width),
    .B_width  (B_width),
    .SUM_width(SUM_width)
  ) u_lane_mac (
    .sel   (lane),
    .a_vec (a_reg),
    .b_lane(b_lane),
    .c     (acc),
    .tc    (tc_reg),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and handshake outputs; DONE never accepts in the same cycle.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (lane == LANE_IDX_W'(LANES-1)) state_n = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture on accept, then one lane accumulate per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane    <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      tc_reg  <= 1'b0;
      acc     <= '0;
      ovf_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg   <= in_a;
          b_reg   <= in_b;
          tc_reg  <= in_tc;
          acc     <= in_c;
          lane    <= '0;
          ovf_reg <= 1'b0;
        end
        RUN: begin
          acc     <= mac_sum;
          lane    <= lane + LANE_IDX_W'(1);
          ovf_reg <= ovf_reg | mac_ovf;
        end
        default: ;
      endcase
    end
  end

  // mac_ovf is constant 0 in the wrapping build, so out_ovf stays 0 there.
  assign out_sum = acc;
  assign out_ovf = ovf_reg;

endmodule

// File: tb/tb_mac_dot8_sequencer.sv
// Scoreboard bench for mac_dot8_sequencer: the driver pushes the
// hand-computed result when a bundle is accepted; a monitor pops and
// compares on every out_valid&&out_ready handshake.
module tb_mac_dot8_sequencer;

  typedef struct {
    logic [21:0] sum;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [21:0] in_c = '0;
  logic        in_tc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [21:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_results = 0;
  int   cyc = 0;
  int   last_hs_edge = -1;
  exp_t exp_q[$];

  mac_dot8_sequencer #(.A_width(8), .B_width(8), .SUM_width(22)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_c     (in_c),
    .in_tc    (in_tc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: every result handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_results++;
      last_hs_edge = cyc + 1;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_sum", 64'(out_sum), 64'(e.sum));
        check("result_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
  end

  // Present a bundle until accepted; returns the accepting edge number.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [21:0] c,
                      input logic tc, input bit hold, input bit push,
                      input logic [21:0] es, input logic eo, output int acc_edge);
    exp_t e;
    e.sum = es;
    e.ovf = eo;
    in_a = a; in_b = b; in_c = c; in_tc = tc; in_valid = 1'b1;
    acc_edge = -1;
    for (int i = 0; i < 60 && acc_edge < 0; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_edge = cyc + 1;
        if (push) exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    if (acc_edge < 0) fail_now("accept");
    if (!hold) in_valid = 1'b0;
  endtask

  // Wait for the DUT to go idle with every expected result consumed.
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!(in_ready && exp_q.size() == 0) && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 60) fail_now(name);
  endtask

  localparam logic [63:0] A_ONES = 64'h0101010101010101;
  localparam logic [63:0] B_RAMP = 64'h0807060504030201;

  initial begin
    int ea, eb, k;
    logic [21:0] exp4;
    logic        ovf4;
`ifdef MAC_DOT8_SAT_EN
    exp4 = 22'h3FFFFF; ovf4 = 1'b1;
`else
    exp4 = 22'h07F007; ovf4 = 1'b0;
`endif

    // Reset state.
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: unsigned ramp, 36; out_valid rises after the 8th edge past accept.
    send(A_ONES, B_RAMP, 22'd0, 1'b0, 1'b0, 1'b1, 22'd36, 1'b0, ea);
    repeat (7) @(posedge clk);
    #1;
    check("lat_edge7_valid", 64'(out_valid), 64'd0);
    check("lat_edge7_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("lat_edge8_valid", 64'(out_valid), 64'd1);
    wait_idle("t1_idle");

    // 2: signed, -1*2 + 10 = 8.
    send(64'hFF, 64'h02, 22'd10, 1'b1, 1'b0, 1'b1, 22'd8, 1'b0, ea);
    wait_idle("t2_idle");

    // 3: backpressure in DONE; in_valid pulses must be ignored.
    out_ready = 1'b0;
    send(A_ONES, B_RAMP, 22'd0, 1'b0, 1'b0, 1'b1, 22'd36, 1'b0, ea);
    k = 0;
    while (!out_valid && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 30) fail_now("t3_valid");
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_a = 64'hA5A5A5A5A5A5A5A5;
      @(posedge clk);
      #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_sum", 64'(out_sum), 64'd36);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_consumed", 64'(busy), 64'd0);
    wait_idle("t3_idle");

    // 4: unsigned all-ones with max seed: wrap or clamp.
    send(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 22'h3FFFFF, 1'b0, 1'b0, 1'b1,
         exp4, ovf4, ea);
    wait_idle("t4_idle");

    // 5: reset at lane 4 discards the operation.
    send(A_ONES, B_RAMP, 22'd0, 1'b0, 1'b0, 1'b0, 22'd0, 1'b0, ea);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) fail_now("rst_ghost_result");
    end
    check("rst_post_ready", 64'(in_ready), 64'd1);
    send(A_ONES, B_RAMP, 22'd0, 1'b0, 1'b0, 1'b1, 22'd36, 1'b0, ea);
    wait_idle("t5_idle");

    // 6: back-to-back with in_valid held; -128*127*8 wraps to 0x3E0400.
    send(64'hFF, 64'h02, 22'd10, 1'b1, 1'b1, 1'b1, 22'd8, 1'b0, ea);
    send(64'h8080808080808080, 64'h7F7F7F7F7F7F7F7F, 22'd0, 1'b1, 1'b0, 1'b1,
         22'h3E0400, 1'b0, eb);
    check("b2b_after_hs", 64'(eb), 64'(last_hs_edge + 1));
    check("b2b_interval", 64'(eb - ea), 64'd10);
    wait_idle("t6_idle");

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("result_count", 64'(n_results), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
